// File: rtl/cr_crcgc_crc_chk.sv
// Streaming CRC checker: recomputes a reflected CRC over each framed payload and
// compares it with the expected CRC carried on the end-of-frame beat. One registered
// pass/fail result per frame, a protocol-error pulse and saturating counters.
module cr_crcgc_crc_chk #(
  parameter int unsigned             N_CRC_WIDTH  = 32,
  parameter int unsigned             N_DATA_WIDTH = 64,
  parameter int unsigned             N_CNT_WIDTH  = 16,
  parameter logic [N_CRC_WIDTH-1:0]  POLYNOMIAL   = 32'h82F63B78,
  parameter logic [N_CRC_WIDTH-1:0]  INIT_VALUE   = 32'hFFFFFFFF,
  parameter logic [N_CRC_WIDTH-1:0]  XOR_OUT      = 32'hFFFFFFFF,
  localparam int unsigned            N_VBYTES_WIDTH = N_DATA_WIDTH / 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_sop,
  input  logic                      in_eop,
  input  logic [N_DATA_WIDTH-1:0]   in_data,
  input  logic [N_VBYTES_WIDTH-1:0] in_vbytes,
  input  logic [N_CRC_WIDTH-1:0]    in_exp_crc,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [N_CRC_WIDTH-1:0]    res_crc,
  output logic                      res_err,
  output logic                      proto_err,
  output logic [N_CNT_WIDTH-1:0]    frame_cnt,
  output logic [N_CNT_WIDTH-1:0]    err_cnt
);

  typedef enum logic [0:0] {StIdle, StInFrame} state_e;

  state_e                   state_q, state_d;
  logic [N_CRC_WIDTH-1:0]   crc_q, crc_d;
  logic                     bad_q, bad_d;
  logic                     res_valid_q, res_valid_d;
  logic [N_CRC_WIDTH-1:0]   res_crc_q, res_crc_d;
  logic                     res_err_q, res_err_d;
  logic                     proto_err_q, proto_err_d;
  logic [N_CNT_WIDTH-1:0]   frame_cnt_q, frame_cnt_d;
  logic [N_CNT_WIDTH-1:0]   err_cnt_q, err_cnt_d;

  logic                     accept;
  logic                     vb_therm;
  logic                     beat_legal;
  int unsigned              nlanes;
  int unsigned              step_lanes;
  logic [N_CRC_WIDTH-1:0]   base_crc;
  logic [N_CRC_WIDTH-1:0]   stepped_crc;
  logic [N_CRC_WIDTH-1:0]   final_crc;
  logic                     frame_beat;
  logic                     bad_next;
  logic                     err_next;

  // Reflected byte-serial CRC over the first nbytes lanes, lane 0 first.
  function automatic logic [N_CRC_WIDTH-1:0] crc_step(input logic [N_CRC_WIDTH-1:0]  crc_in,
                                                      input logic [N_DATA_WIDTH-1:0] data,
                                                      input int unsigned             nbytes);
    logic [N_CRC_WIDTH-1:0] c;
    c = crc_in;
    for (int unsigned i = 0; i < N_VBYTES_WIDTH; i++) begin
      if (i < nbytes) begin
        c = c ^ {{(N_CRC_WIDTH-8){1'b0}}, data[8*i +: 8]};
        for (int unsigned j = 0; j < 8; j++) begin
          c = c[0] ? ((c >> 1) ^ POLYNOMIAL) : (c >> 1);
        end
      end
    end
    return c;
  endfunction

  // Upstream is stalled only while a result waits; a disabled checker sinks everything.
  assign in_ready = rst_n & (~enable | ~(res_valid_q & ~res_ready));
  assign accept   = in_valid & in_ready & enable;

  // Lane qualification: thermometer shape and lane count of in_vbytes.
  always_comb begin
    vb_therm = 1'b1;
    nlanes   = 0;
    for (int unsigned i = 0; i < N_VBYTES_WIDTH; i++) begin
      if (in_vbytes[i]) nlanes = nlanes + 32'd1;
    end
    for (int unsigned i = 1; i < N_VBYTES_WIDTH; i++) begin
      if (in_vbytes[i] && !in_vbytes[i-1]) vb_therm = 1'b0;
    end
    // Non-thermometer masks cannot be mapped to a byte count, so they add nothing.
    step_lanes = vb_therm ? nlanes : 0;
    beat_legal = in_eop ? (vb_therm & (|in_vbytes)) : (&in_vbytes);
  end

  // CRC datapath for the current beat.
  always_comb begin
    base_crc    = in_sop ? INIT_VALUE : crc_q;
    stepped_crc = crc_step(base_crc, in_data, step_lanes);
    final_crc   = stepped_crc ^ XOR_OUT;
    frame_beat  = in_sop | (state_q == StInFrame);
    bad_next    = (in_sop ? 1'b0 : bad_q) | ~beat_legal;
    err_next    = bad_next | (final_crc != in_exp_crc);
  end

  // Next-state: frame tracking, result register and counters.
  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    bad_d       = bad_q;
    proto_err_d = 1'b0;
    res_valid_d = res_valid_q & ~res_ready;
    res_crc_d   = res_crc_q;
    res_err_d   = res_err_q;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;

    if (!enable) begin
      state_d = StIdle;
      crc_d   = INIT_VALUE;
      bad_d   = 1'b0;
    end else if (accept) begin
      proto_err_d = (in_sop & (state_q == StInFrame)) |
                    (~in_sop & (state_q == StIdle)) |
                    ~beat_legal;
      if (frame_beat) begin
        if (in_eop) begin
          state_d     = StIdle;
          crc_d       = INIT_VALUE;
          bad_d       = 1'b0;
          res_valid_d = 1'b1;
          res_crc_d   = final_crc;
          res_err_d   = err_next;
          if (!(&frame_cnt_q)) frame_cnt_d = frame_cnt_q + N_CNT_WIDTH'(1);
          if (err_next && !(&err_cnt_q)) err_cnt_d = err_cnt_q + N_CNT_WIDTH'(1);
        end else begin
          state_d = StInFrame;
          crc_d   = stepped_crc;
          bad_d   = bad_next;
        end
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      crc_q       <= INIT_VALUE;
      bad_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_crc_q   <= '0;
      res_err_q   <= 1'b0;
      proto_err_q <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      bad_q       <= bad_d;
      res_valid_q <= res_valid_d;
      res_crc_q   <= res_crc_d;
      res_err_q   <= res_err_d;
      proto_err_q <= proto_err_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_crc   = res_crc_q;
  assign res_err   = res_err_q;
  assign proto_err = proto_err_q;
  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_cr_crcgc_crc_chk.sv
// Self-checking bench for cr_crcgc_crc_chk: directed CRC32C vectors plus randomized
// frames scored against a frame-level byte-queue model.
`timescale 1ns / 1ps
module tb_cr_crcgc_crc_chk;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        in_valid;
  logic        in_ready;
  logic        in_sop;
  logic        in_eop;
  logic [63:0] in_data;
  logic [7:0]  in_vbytes;
  logic [31:0] in_exp_crc;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_crc;
  logic        res_err;
  logic        proto_err;
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;

  always #5 clk = ~clk;

  cr_crcgc_crc_chk dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sop     (in_sop),
    .in_eop     (in_eop),
    .in_data    (in_data),
    .in_vbytes  (in_vbytes),
    .in_exp_crc (in_exp_crc),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_crc    (res_crc),
    .res_err    (res_err),
    .proto_err  (proto_err),
    .frame_cnt  (frame_cnt),
    .err_cnt    (err_cnt)
  );

  typedef struct packed {
    logic [31:0] crc;
    logic        err;
  } res_t;

  int   checks = 0;
  int   errors = 0;
  res_t exp_q[$];
  res_t obs_q[$];
  int   sb_idx = 0;
  int   obs_proto = 0;
  int   m_proto_exp = 0;
  bit   sb_skip = 0;

  // Frame-level reference model state.
  bit          m_in_frame = 0;
  bit          m_bad = 0;
  logic [7:0]  m_bytes[$];
  logic [15:0] m_frames = 0;
  logic [15:0] m_errs = 0;

  localparam logic [63:0] Vec0 = 64'h3837363534333231;
  localparam logic [63:0] Vec1 = 64'h0000000000000039;
  localparam logic [31:0] VecCrc = 32'hE3069283;

  // CRC32C over a whole byte string, as defined (reflected, init/xorout all-ones).
  function automatic logic [31:0] ref_crc32c(input logic [7:0] b[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      c ^= {24'h0, b[i]};
      repeat (8) c = c[0] ? ((c >> 1) ^ 32'h82F63B78) : (c >> 1);
    end
    return ~c;
  endfunction

  // Applies one accepted beat to the frame model.
  task automatic model_beat();
    int   k;
    bit   therm;
    bit   legal;
    bit   proto;
    logic [31:0] c;
    bit   e;
    k     = $countones(in_vbytes);
    therm = (int'(in_vbytes) == ((1 << k) - 1));
    legal = in_eop ? (therm && k != 0) : (in_vbytes == 8'hFF);
    proto = !legal;
    if (in_sop) begin
      if (m_in_frame) proto = 1;
      m_bytes.delete();
      m_bad      = 0;
      m_in_frame = 1;
    end else if (!m_in_frame) begin
      proto = 1;
    end
    if (proto) m_proto_exp++;
    if (m_in_frame) begin
      if (therm) for (int i = 0; i < k; i++) m_bytes.push_back(in_data[8*i +: 8]);
      if (!legal) m_bad = 1;
      if (in_eop) begin
        c = ref_crc32c(m_bytes);
        e = m_bad || (c != in_exp_crc);
        if (!sb_skip) exp_q.push_back('{crc: c, err: e});
        if (m_frames != 16'hFFFF) m_frames++;
        if (e && m_errs != 16'hFFFF) m_errs++;
        m_in_frame = 0;
      end
    end
  endtask

  // Observes handshakes mid-cycle, when inputs and combinational ready have settled.
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      m_in_frame = 0;
      m_frames   = 0;
      m_errs     = 0;
    end else begin
      if (proto_err) obs_proto++;
      if (res_valid && res_ready && !sb_skip) obs_q.push_back('{crc: res_crc, err: res_err});
      if (!enable) m_in_frame = 0;
      else if (in_valid && in_ready) model_beat();
    end
  end

  // Presents one beat (call at a falling edge) and holds it until accepted.
  task automatic send_beat(input bit sop, input bit eop, input logic [63:0] d,
                           input logic [7:0] vb, input logic [31:0] exp_crc);
    bit done;
    done       = 0;
    in_valid   = 1;
    in_sop     = sop;
    in_eop     = eop;
    in_data    = d;
    in_vbytes  = vb;
    in_exp_crc = exp_crc;
    for (int n = 0; n < 100 && !done; n++) begin
      #1;
      if (in_ready) done = 1;
      @(negedge clk);
    end
    in_valid = 0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_beat_timeout: in_ready stayed 0, required 1 within 100 cycles");
    end
  endtask

  task automatic send_vector(input logic [31:0] exp_crc);
    send_beat(1, 0, Vec0, 8'hFF, exp_crc);
    send_beat(0, 1, Vec1, 8'h01, exp_crc);
  endtask

  task automatic test_reset();
    rst_n     = 0;
    enable    = 1;
    res_ready = 1;
    in_valid  = 0;
    in_sop    = 0;
    in_eop    = 0;
    in_data   = '0;
    in_vbytes = '0;
    in_exp_crc = '0;
    repeat (3) @(negedge clk);
    checks += 7;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
    if (res_crc !== 32'h0) begin errors++; $display("FAIL reset_res_crc: got %h want 0", res_crc); end
    if (res_err !== 1'b0) begin errors++; $display("FAIL reset_res_err: got %b want 0", res_err); end
    if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto_err: got %b want 0", proto_err); end
    if (frame_cnt !== 16'h0) begin errors++; $display("FAIL reset_frame_cnt: got %h want 0", frame_cnt); end
    if (err_cnt !== 16'h0) begin errors++; $display("FAIL reset_err_cnt: got %h want 0", err_cnt); end
    rst_n = 1;
    @(negedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_known_vector();
    res_ready = 0;
    send_vector(VecCrc);
    checks += 5;
    if (res_valid !== 1'b1) begin errors++; $display("FAIL vec_res_valid: got %b want 1", res_valid); end
    if (res_crc !== VecCrc) begin errors++; $display("FAIL vec_res_crc: got %h want %h", res_crc, VecCrc); end
    if (res_err !== 1'b0) begin errors++; $display("FAIL vec_res_err: got %b want 0", res_err); end
    if (frame_cnt !== 16'd1) begin errors++; $display("FAIL vec_frame_cnt: got %0d want 1", frame_cnt); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL vec_in_ready_stall: got %b want 0", in_ready); end
    res_ready = 1;
    @(negedge clk);
    send_vector(VecCrc + 32'd1);
    checks += 4;
    if (res_crc !== VecCrc) begin errors++; $display("FAIL vecbad_res_crc: got %h want %h", res_crc, VecCrc); end
    if (res_err !== 1'b1) begin errors++; $display("FAIL vecbad_res_err: got %b want 1", res_err); end
    if (err_cnt !== 16'd1) begin errors++; $display("FAIL vecbad_err_cnt: got %0d want 1", err_cnt); end
    if (frame_cnt !== 16'd2) begin errors++; $display("FAIL vecbad_frame_cnt: got %0d want 2", frame_cnt); end
    repeat (2) @(negedge clk);
    sb_idx = obs_q.size();
  endtask

  task automatic test_backpressure();
    int          base;
    bit          seen;
    logic [7:0]  bytes[$];
    logic [63:0] d[3];
    base = obs_q.size();
    res_ready = 1;
    for (int b = 0; b < 3; b++) begin
      d[b] = {$urandom, $urandom};
      for (int i = 0; i < 8; i++) bytes.push_back(d[b][8*i +: 8]);
    end
    fork
      begin
        send_vector(VecCrc);
        send_beat(1, 0, d[0], 8'hFF, 32'h0);
        send_beat(0, 0, d[1], 8'hFF, 32'h0);
        send_beat(0, 1, d[2], 8'hFF, ref_crc32c(bytes));
      end
      begin
        seen = 0;
        for (int n = 0; n < 60 && !seen; n++) begin
          @(negedge clk);
          if (res_valid) seen = 1;
        end
        checks++;
        if (!seen) begin
          errors++;
          $display("FAIL bp_result_timeout: res_valid stayed 0, required 1");
        end else begin
          res_ready = 0;
          for (int n = 0; n < 5; n++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
              errors++;
              $display("FAIL bp_in_ready: got %b want 0 while result held", in_ready);
            end
            @(negedge clk);
          end
          res_ready = 1;
        end
      end
    join
    repeat (4) @(negedge clk);
    checks += 2;
    if (obs_q.size() - base != 2) begin
      errors++;
      $display("FAIL bp_result_count: got %0d want 2", obs_q.size() - base);
    end else if (obs_q[base] !== res_t'({VecCrc, 1'b0})) begin
      errors++;
      $display("FAIL bp_first_result: got %h want %h", obs_q[base], res_t'({VecCrc, 1'b0}));
    end
    for (int k = sb_idx; k < obs_q.size(); k++) begin
      checks++;
      if (k >= exp_q.size()) begin
        errors++; $display("FAIL bp_sb_extra: got %h want no result", obs_q[k]);
      end else if (obs_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL bp_sb_result: got %h want %h", obs_q[k], exp_q[k]);
      end
    end
    sb_idx = obs_q.size();
  endtask

  task automatic test_sop_mid_frame();
    int pbase;
    int base;
    pbase = obs_proto;
    base  = obs_q.size();
    send_beat(1, 0, {$urandom, $urandom}, 8'hFF, 32'h0);
    send_vector(VecCrc);
    repeat (3) @(negedge clk);
    checks += 2;
    if (obs_proto - pbase != 1) begin
      errors++; $display("FAIL sop_mid_proto_pulses: got %0d want 1", obs_proto - pbase);
    end
    if (obs_q.size() - base != 1) begin
      errors++; $display("FAIL sop_mid_result_count: got %0d want 1", obs_q.size() - base);
    end else begin
      checks++;
      if (obs_q[base] !== res_t'({VecCrc, 1'b0})) begin
        errors++; $display("FAIL sop_mid_result: got %h want %h", obs_q[base], res_t'({VecCrc, 1'b0}));
      end
    end
    sb_idx = obs_q.size();
  endtask

  task automatic test_bad_vbytes();
    int          pbase;
    logic [7:0]  bytes[$];
    logic [63:0] d0;
    logic [63:0] d1;
    d0 = {$urandom, $urandom};
    d1 = {$urandom, $urandom};
    for (int i = 0; i < 8; i++) bytes.push_back(d0[8*i +: 8]);
    for (int i = 0; i < 4; i++) bytes.push_back(d1[8*i +: 8]);
    bytes.push_back(8'h39);
    pbase = obs_proto;
    // Expected CRC matches the bytes actually covered; the frame must still be flagged.
    send_beat(1, 0, d0, 8'hFF, 32'h0);
    send_beat(0, 0, d1, 8'h0F, 32'h0);
    send_beat(0, 1, Vec1, 8'h01, ref_crc32c(bytes));
    checks += 3;
    if (res_err !== 1'b1) begin errors++; $display("FAIL badvb_res_err: got %b want 1", res_err); end
    if (res_crc !== ref_crc32c(bytes)) begin
      errors++; $display("FAIL badvb_res_crc: got %h want %h", res_crc, ref_crc32c(bytes));
    end
    repeat (2) @(negedge clk);
    if (obs_proto - pbase != 1) begin
      errors++; $display("FAIL badvb_proto_pulses: got %0d want 1", obs_proto - pbase);
    end
    sb_idx = obs_q.size();
  endtask

  task automatic test_random();
    int pbase;
    int mbase;
    bit done;
    pbase = obs_proto;
    mbase = m_proto_exp;
    done  = 0;
    fork
      begin
        for (int f = 0; f < 40; f++) begin
          logic [7:0]  bytes[$];
          int          nb;
          logic [63:0] d;
          logic [7:0]  vb;
          logic [31:0] c;
          bit          sop;
          nb = $urandom_range(1, 4);
          for (int b = 0; b < nb; b++) begin
            d   = {$urandom, $urandom};
            vb  = (b == nb - 1) ? 8'((1 << $urandom_range(1, 8)) - 1) : 8'hFF;
            if ($urandom_range(0, 15) == 0) vb = 8'($urandom);
            sop = (b == 0) && ($urandom_range(0, 19) != 0);
            for (int i = 0; i < 8; i++) if (vb[i]) bytes.push_back(d[8*i +: 8]);
            c = ref_crc32c(bytes);
            if ($urandom_range(0, 3) == 0) c = c ^ 32'h1;
            send_beat(sop, b == nb - 1, d, vb, c);
          end
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          res_ready = ($urandom_range(0, 3) != 0);
        end
        res_ready = 1;
      end
    join
    repeat (4) @(negedge clk);
    checks += 2;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_result_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    if (obs_proto - pbase != m_proto_exp - mbase) begin
      errors++;
      $display("FAIL rand_proto_pulses: got %0d want %0d", obs_proto - pbase, m_proto_exp - mbase);
    end
    for (int k = sb_idx; k < obs_q.size(); k++) begin
      checks++;
      if (k >= exp_q.size()) begin
        errors++; $display("FAIL rand_sb_extra: got %h want no result", obs_q[k]);
      end else if (obs_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL rand_sb_result[%0d]: got %h want %h", k, obs_q[k], exp_q[k]);
      end
    end
    sb_idx = obs_q.size();
    checks += 2;
    if (frame_cnt !== m_frames) begin errors++; $display("FAIL rand_frame_cnt: got %0d want %0d", frame_cnt, m_frames); end
    if (err_cnt !== m_errs) begin errors++; $display("FAIL rand_err_cnt: got %0d want %0d", err_cnt, m_errs); end
  endtask

  task automatic test_enable_off();
    logic [15:0] fc;
    logic [15:0] ec;
    int          base;
    int          pbase;
    res_ready = 0;
    send_vector(VecCrc);
    fc   = m_frames;
    ec   = m_errs;
    base = obs_q.size();
    // Disabled with a result pending: beats sunk, pending result still drains.
    enable    = 0;
    in_valid  = 1;
    in_sop    = 1;
    in_eop    = 0;
    in_vbytes = 8'hFF;
    #1;
    checks += 2;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL en_off_in_ready: got %b want 1", in_ready); end
    if (res_valid !== 1'b1) begin errors++; $display("FAIL en_off_pending: got %b want 1", res_valid); end
    @(negedge clk);
    in_sop    = 0;
    in_eop    = 1;
    in_vbytes = 8'h01;
    res_ready = 1;
    repeat (3) @(negedge clk);
    in_valid = 0;
    enable   = 1;
    @(negedge clk);
    // Frame cut by a disable: the tail beat arrives in IDLE and is dropped.
    pbase = obs_proto;
    send_beat(1, 0, Vec0, 8'hFF, 32'h0);
    enable = 0;
    @(negedge clk);
    enable = 1;
    send_beat(0, 1, Vec1, 8'h01, VecCrc);
    repeat (3) @(negedge clk);
    checks += 4;
    if (frame_cnt !== fc) begin errors++; $display("FAIL en_off_frame_cnt: got %0d want %0d", frame_cnt, fc); end
    if (err_cnt !== ec) begin errors++; $display("FAIL en_off_err_cnt: got %0d want %0d", err_cnt, ec); end
    if (obs_proto - pbase != 1) begin
      errors++; $display("FAIL en_off_proto: got %0d want 1", obs_proto - pbase);
    end
    if (obs_q.size() - base != 1) begin
      errors++; $display("FAIL en_off_results: got %0d want 1", obs_q.size() - base);
    end else begin
      checks++;
      if (obs_q[base] !== res_t'({VecCrc, 1'b0})) begin
        errors++; $display("FAIL en_off_drained: got %h want %h", obs_q[base], res_t'({VecCrc, 1'b0}));
      end
    end
    sb_idx = obs_q.size();
  endtask

  task automatic test_saturation();
    int n;
    n = 65535 - int'(m_errs) + 4;
    sb_skip    = 1;
    res_ready  = 1;
    in_valid   = 1;
    in_sop     = 1;
    in_eop     = 1;
    in_data    = '0;
    in_vbytes  = 8'hFF;
    in_exp_crc = 32'h0;
    repeat (n) @(negedge clk);
    in_valid = 0;
    repeat (2) @(negedge clk);
    sb_skip = 0;
    checks += 3;
    if (err_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_err_cnt: got %h want ffff", err_cnt); end
    if (frame_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_frame_cnt: got %h want ffff", frame_cnt); end
    if (m_errs !== 16'hFFFF) begin errors++; $display("FAIL sat_model_errs: got %h want ffff", m_errs); end
    send_vector(32'h0);
    repeat (2) @(negedge clk);
    checks += 2;
    if (err_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold_err: got %h want ffff", err_cnt); end
    if (frame_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold_frame: got %h want ffff", frame_cnt); end
    sb_idx = obs_q.size();
  endtask

  task automatic test_reset_mid_frame();
    int base;
    repeat (2) @(negedge clk);
    base = obs_q.size();
    send_beat(1, 0, Vec0, 8'hFF, 32'h0);
    rst_n = 0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_in_ready: got %b want 0", in_ready); end
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    checks += 3;
    if (frame_cnt !== 16'h0) begin errors++; $display("FAIL rst_mid_frame_cnt: got %h want 0", frame_cnt); end
    if (err_cnt !== 16'h0) begin errors++; $display("FAIL rst_mid_err_cnt: got %h want 0", err_cnt); end
    if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_res_valid: got %b want 0", res_valid); end
    // The tail of the cut frame must not complete it.
    send_beat(0, 1, Vec1, 8'h01, VecCrc);
    send_vector(VecCrc);
    checks += 3;
    if (res_crc !== VecCrc) begin errors++; $display("FAIL rst_mid_crc: got %h want %h", res_crc, VecCrc); end
    if (res_err !== 1'b0) begin errors++; $display("FAIL rst_mid_err: got %b want 0", res_err); end
    if (frame_cnt !== 16'd1) begin errors++; $display("FAIL rst_mid_count: got %0d want 1", frame_cnt); end
    repeat (2) @(negedge clk);
    checks++;
    if (obs_q.size() - base != 1) begin
      errors++; $display("FAIL rst_mid_results: got %0d want 1", obs_q.size() - base);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_known_vector();
    test_backpressure();
    test_sop_mid_frame();
    test_bad_vbytes();
    test_random();
    test_enable_off();
    test_saturation();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
